forest_scheduler: RTL and testbench
===================================

FOREST_SCHEDULER -- requirements
Module: forest_scheduler

Interface
REQ-001 SHALL have parameter NUM_TREES, default 5, number of trees evaluated per sample (odd, 1..15).
REQ-002 SHALL have parameter FEAT_W, default 16, signed Q8.8 feature width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum engine wait per tree.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  2  sample offered, one bit per requester.
REQ-007 SHALL have port req_ready  output  2  sample accepted, one bit per requester.
REQ-008 SHALL have port req_data  input  2*11*FEAT_W  packed samples; requester r occupies slice r, feature i at bits i*FEAT_W.
REQ-009 SHALL have port rsp_valid  output  2  result available, one bit per requester.
REQ-010 SHALL have port rsp_ready  input  2  result consumed, one bit per requester.
REQ-011 SHALL have port rsp_label  output  2  majority label, one bit per requester.
REQ-012 SHALL have port rsp_err  output  2  evaluation aborted by timeout, one bit per requester.
REQ-013 SHALL have port eng_start  output  1  one-cycle start pulse to the shared tree engine.
REQ-014 SHALL have port eng_tree_sel  output  4  index of the tree to evaluate.
REQ-015 SHALL have port eng_data  output  11*FEAT_W  latched sample driven to the engine.
REQ-016 SHALL have port eng_done  input  1  engine result valid, single-cycle pulse.
REQ-017 SHALL have port eng_label  input  1  engine label, qualified by eng_done.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, VOTE, RESP.
REQ-020 SHALL, in IDLE with any req_valid high, grant exactly one requester round-robin, assert its req_ready combinationally that cycle, latch its sample, clear vote count and tree index, go to ISSUE.
REQ-021 SHALL, on simultaneous req_valid, grant the requester not granted most recently; after reset requester 0 has priority.
REQ-022 SHALL hold req_ready low in every state other than IDLE.
REQ-023 SHALL in ISSUE assert eng_start for exactly one cycle with eng_tree_sel equal to tree index, then go to WAIT.
REQ-024 SHALL ignore eng_done in any state other than WAIT.
REQ-025 SHALL in WAIT, on eng_done, add eng_label to vote count, increment tree index, go to ISSUE if index < NUM_TREES else VOTE.
REQ-026 SHALL in VOTE set label = (vote count > NUM_TREES/2, integer division), go to RESP.
REQ-027 SHALL in RESP hold rsp_valid of the granted requester high, with stable rsp_label/rsp_err, until its rsp_ready is high; then return to IDLE.
REQ-028 SHALL deliver rsp_valid at T+2*NUM_TREES+2 when accepted at cycle T and the engine answers in the first WAIT cycle.
REQ-029 SHALL size vote count to hold NUM_TREES without wrap.
REQ-030 SHALL keep eng_data stable from acceptance until leaving RESP.

Reset
REQ-031 SHALL, on reset low at any time, including mid-evaluation, go to IDLE immediately with req_ready, rsp_valid, rsp_label, rsp_err, eng_start, busy at 0, eng_tree_sel 0, round-robin pointer favouring requester 0; an in-flight sample is dropped.

Configuration
REQ-032 SHALL, with FOREST_TIMEOUT_EN defined, count WAIT cycles per tree and, on reaching TIMEOUT_CYCLES without eng_done, go to RESP with rsp_err=1, rsp_label=0.
REQ-033 SHALL, without FOREST_TIMEOUT_EN, wait in WAIT indefinitely, tie rsp_err to 0, instantiate no timeout counter.

Structure
REQ-034 SHALL take NUM_FEAT=11, feature index constants (alcohol=0 .. fixed acidity=10), the state enum and sample typedef from shared package forest_pkg.
REQ-035 SHALL instantiate one sub-module rr_arbiter2 for the two-requester round-robin grant.

Verification
REQ-036 SHALL check: single request on requester 0, engine labels 1,1,0,1,0 with 1-cycle latency -> rsp_label[0]=1, rsp_valid[0] at T+12.
REQ-037 SHALL check: both req_valid high from reset -> requester 0 served first, then requester 1; second dual request -> requester 1 first.
REQ-038 SHALL check: labels 0,1,0,1,0 -> rsp_label=0; rsp_ready held low 10 cycles -> rsp_valid and label stable, no new req_ready.
REQ-039 SHALL check: eng_done pulsed during ISSUE and IDLE -> ignored, vote count unchanged.
REQ-040 SHALL check: with FOREST_TIMEOUT_EN, engine silent on tree 2 -> rsp_err=1, rsp_label=0 after 64 WAIT cycles.
REQ-041 SHALL check: reset asserted during WAIT of tree 3 -> all outputs 0 next edge, following request evaluated from tree 0.

Source files
------------

// File: rtl/forest_pkg.sv
// Shared definitions for the random-forest scheduler: feature layout, FSM states, sample type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package forest_pkg;

    // Number of features carried by one sample.
    localparam int NUM_FEAT = 11;

    // Position of each feature inside a packed sample (feature i sits at bits i*FEAT_W).
    localparam int FEAT_ALCOHOL          = 0;
    localparam int FEAT_VOLATILE_ACIDITY = 1;
    localparam int FEAT_SULPHATES        = 2;
    localparam int FEAT_TOTAL_SO2        = 3;
    localparam int FEAT_DENSITY          = 4;
    localparam int FEAT_CHLORIDES        = 5;
    localparam int FEAT_FREE_SO2         = 6;
    localparam int FEAT_PH               = 7;
    localparam int FEAT_CITRIC_ACID      = 8;
    localparam int FEAT_RESIDUAL_SUGAR   = 9;
    localparam int FEAT_FIXED_ACIDITY    = 10;

    // Default Q8.8 feature width.
    localparam int DEF_FEAT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        VOTE,
        RESP
    } state_t;

    // One sample at the default feature width, indexable by the FEAT_* constants.
    typedef logic [NUM_FEAT-1:0][DEF_FEAT_W-1:0] sample_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the requester not granted most recently wins a tie.
// Latency: grant is combinational from req; priority pointer updates on the accepting edge.
// Backpressure: pointer only moves when the grant is actually taken (accept high).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the requester that currently holds priority; requester 0 after reset.
    logic pri;

    // Pick the priority requester if it asks, otherwise the other one.
    always_comb begin
        grant = 2'b00;
        if (!pri) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    // Hand priority to the requester that was not just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                pri <= 1'b0;
        else if (accept && |grant) pri <= grant[0];
    end

endmodule

// File: rtl/forest_scheduler.sv
// Runs each accepted sample through NUM_TREES trees on a shared engine and returns the majority label.
// Latency: rsp_valid 2*NUM_TREES+2 cycles after acceptance with a 1-cycle engine; optional timeout via FOREST_TIMEOUT_EN.
// Backpressure: one sample in flight; req_ready only in IDLE; result held in RESP until the owner's rsp_ready.
module forest_scheduler
    import forest_pkg::*;
#(
    parameter int NUM_TREES      = 5,
    parameter int FEAT_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [2*NUM_FEAT*FEAT_W-1:0] req_data,
    output logic [1:0]                   rsp_valid,
    input  logic [1:0]                   rsp_ready,
    output logic [1:0]                   rsp_label,
    output logic [1:0]                   rsp_err,
    output logic                         eng_start,
    output logic [3:0]                   eng_tree_sel,
    output logic [NUM_FEAT*FEAT_W-1:0]   eng_data,
    input  logic                         eng_done,
    input  logic                         eng_label,
    output logic                         busy
);

    localparam int SW = NUM_FEAT * FEAT_W;
    localparam int VW = $clog2(NUM_TREES + 1);

    state_t          state;
    logic            owner;
    logic [1:0]      owner_oh;
    logic [3:0]      tree_idx;
    logic [VW-1:0]   vote_cnt;
    logic [SW-1:0]   sample_q;
    logic [1:0]      grant;
    logic            accept;
    logic            last_tree;
    logic            timeout;

    assign accept       = (state == IDLE) && (|req_valid);
    assign req_ready    = (state == IDLE) ? grant : 2'b00;
    assign owner_oh     = owner ? 2'b10 : 2'b01;
    assign last_tree    = (tree_idx + 4'd1) >= 4'(NUM_TREES);
    assign busy         = (state != IDLE);
    assign eng_tree_sel = tree_idx;
    assign eng_data     = sample_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

`ifdef FOREST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Count cycles spent waiting on the current tree; restarts every time WAIT is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              to_cnt <= '0;
        else if (state == WAIT)  to_cnt <= to_cnt + TW'(1);
        else                     to_cnt <= '0;
    end

    assign timeout = (state == WAIT) && !eng_done && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Mark the owner's response as aborted on timeout; cleared when the response is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  rsp_err <= 2'b00;
        else if (timeout)                            rsp_err <= owner_oh;
        else if (state == RESP && rsp_ready[owner])  rsp_err <= 2'b00;
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 2'b00;
`endif

    // Main sequencer: accept, issue each tree, collect votes, present the majority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            tree_idx  <= 4'd0;
            vote_cnt  <= '0;
            sample_q  <= '0;
            eng_start <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_label <= 2'b00;
        end else begin
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= grant[1];
                        sample_q  <= grant[1] ? req_data[2*SW-1:SW] : req_data[SW-1:0];
                        vote_cnt  <= '0;
                        tree_idx  <= 4'd0;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        vote_cnt <= vote_cnt + VW'(eng_label);
                        tree_idx <= tree_idx + 4'd1;
                        if (last_tree) begin
                            state <= VOTE;
                        end else begin
                            eng_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end else if (timeout) begin
                        rsp_valid <= owner_oh;
                        rsp_label <= 2'b00;
                        state     <= RESP;
                    end
                end
                VOTE: begin
                    rsp_valid <= owner_oh;
                    rsp_label <= (vote_cnt > VW'(NUM_TREES / 2)) ? owner_oh : 2'b00;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        rsp_label <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_forest_scheduler.sv
// Directed bench for forest_scheduler: arbitration, voting, latency, backpressure, reset, optional timeout.
// Latency: drives on falling edges, samples on falling edges (away from the rising active edge).
// Backpressure: engine model answers one cycle after each start; rsp_ready driven per test.
`timescale 1ns/1ps
module tb_forest_scheduler;
    import forest_pkg::*;

    localparam int NT = 5;
    localparam int FW = 16;
    localparam int SW = NUM_FEAT * FW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*SW-1:0] req_data = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b00;
    logic [1:0]      rsp_label;
    logic [1:0]      rsp_err;
    logic            eng_start;
    logic [3:0]      eng_tree_sel;
    logic [SW-1:0]   eng_data;
    logic            eng_done = 1'b0;
    logic            eng_label = 1'b0;
    logic            busy;

    forest_scheduler #(.NUM_TREES(NT), .FEAT_W(FW), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_label    (rsp_label),
        .rsp_err      (rsp_err),
        .eng_start    (eng_start),
        .eng_tree_sel (eng_tree_sel),
        .eng_data     (eng_data),
        .eng_done     (eng_done),
        .eng_label    (eng_label),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: per-tree labels, optional silent tree, optional spurious done in ISSUE/IDLE.
    logic lbl [0:15];
    int   silent_tree = -1;
    bit   spur = 1'b0;
    int   idle_req = 0;
    int   starts = 0;

    initial begin : engine
        bit         pend;
        logic [3:0] psel;
        logic       nd, nl;
        int         idle_served;
        pend = 1'b0;
        psel = 4'd0;
        idle_served = 0;
        forever begin
            @(negedge clk);
            nd = 1'b0;
            nl = 1'b0;
            if (pend) begin
                nd = 1'b1;
                nl = lbl[psel];
                pend = 1'b0;
            end else if (eng_start) begin
                starts++;
                if (int'(eng_tree_sel) != silent_tree) begin
                    pend = 1'b1;
                    psel = eng_tree_sel;
                end
                if (spur) begin
                    nd = 1'b1;
                    nl = 1'b1;
                end
            end
            if (idle_req != idle_served) begin
                nd = 1'b1;
                nl = 1'b1;
                idle_served = idle_req;
            end
            eng_done  = nd;
            eng_label = nl;
        end
    end

    task automatic set_labels(input logic [4:0] l);
        for (int i = 0; i < 16; i++) lbl[i] = 1'b0;
        for (int i = 0; i < 5; i++) lbl[i] = l[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".req_ready"}, SW'(req_ready), SW'(0));
        check_eq({tag, ".rsp_valid"}, SW'(rsp_valid), SW'(0));
        check_eq({tag, ".rsp_label"}, SW'(rsp_label), SW'(0));
        check_eq({tag, ".rsp_err"},   SW'(rsp_err),   SW'(0));
        check_eq({tag, ".eng_start"}, SW'(eng_start), SW'(0));
        check_eq({tag, ".busy"},      SW'(busy),      SW'(0));
        check_eq({tag, ".tree_sel"},  SW'(eng_tree_sel), SW'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs(tag);
        reset = 1'b1;
    endtask

    // Offer vld at a falling edge, check the combinational grant, return the accept cycle.
    // Returns at the falling edge of the first ISSUE cycle with req_valid dropped.
    task automatic request(input string tag, input logic [1:0] vld, input logic [1:0] exp_rdy,
                           output int t_acc);
        @(negedge clk);
        req_valid = vld;
        #1;
        check_eq({tag, ".req_ready"}, SW'(req_ready), SW'(exp_rdy));
        t_acc = cyc;
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic wait_rsp(input string tag, input int r, input int t_acc, input int exp_lat);
        int n;
        n = 0;
        while (!rsp_valid[r] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".latency"}, SW'(cyc - t_acc), SW'(exp_lat));
    endtask

    task automatic take_rsp(input string tag, input int r);
        rsp_ready = 2'b01 << r;
        @(negedge clk);
        rsp_ready = 2'b00;
        check_eq({tag, ".rsp_valid_clr"}, SW'(rsp_valid), SW'(0));
        check_eq({tag, ".busy_clr"},      SW'(busy),      SW'(0));
    endtask

    initial begin : main
        sample_t sa, sb;
        int t, s0;

        for (int i = 0; i < NUM_FEAT; i++) begin
            sa[i] = 16'h0100 * 16'(i + 1) + 16'h0013;
            sb[i] = 16'hF000 - 16'h0111 * 16'(i);
        end
        sa[FEAT_ALCOHOL]       = 16'h0A80;
        sb[FEAT_FIXED_ACIDITY] = 16'h0733;
        req_data = {sb, sa};
        set_labels(5'b00000);

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Single request on requester 0, labels 1,1,0,1,0 -> label 1 at T+12
        set_labels(5'b01011);
        s0 = starts;
        request("t1", 2'b01, 2'b01, t);
        check_eq("t1.eng_start", SW'(eng_start), SW'(1));
        check_eq("t1.tree_sel0", SW'(eng_tree_sel), SW'(0));
        check_eq("t1.eng_data",  eng_data, SW'(sa));
        check_eq("t1.busy",      SW'(busy), SW'(1));
        wait_rsp("t1", 0, t, 2 * NT + 2);
        check_eq("t1.rsp_valid", SW'(rsp_valid), SW'(2'b01));
        check_eq("t1.rsp_label", SW'(rsp_label), SW'(2'b01));
        check_eq("t1.rsp_err",   SW'(rsp_err),   SW'(0));
        check_eq("t1.starts",    SW'(starts - s0), SW'(NT));
        take_rsp("t1", 0);

        // Round robin from reset: dual -> 0, dual -> 1, dual -> 0
        do_reset("t2.reset");
        request("t2a", 2'b11, 2'b01, t);
        check_eq("t2a.eng_data", eng_data, SW'(sa));
        wait_rsp("t2a", 0, t, 2 * NT + 2);
        take_rsp("t2a", 0);
        request("t2b", 2'b11, 2'b10, t);
        check_eq("t2b.eng_data", eng_data, SW'(sb));
        wait_rsp("t2b", 1, t, 2 * NT + 2);
        check_eq("t2b.rsp_label", SW'(rsp_label), SW'(2'b10));
        take_rsp("t2b", 1);
        request("t2c", 2'b11, 2'b01, t);
        wait_rsp("t2c", 0, t, 2 * NT + 2);
        take_rsp("t2c", 0);

        // Labels 0,1,0,1,0 -> label 0; response held 10 cycles under backpressure
        set_labels(5'b01010);
        request("t3", 2'b10, 2'b10, t);
        check_eq("t3.eng_data", eng_data, SW'(sb));
        wait_rsp("t3", 1, t, 2 * NT + 2);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            check_eq("t3.hold_valid", SW'(rsp_valid), SW'(2'b10));
            check_eq("t3.hold_label", SW'(rsp_label), SW'(2'b00));
            check_eq("t3.hold_ready", SW'(req_ready), SW'(2'b00));
            check_eq("t3.hold_data",  eng_data, SW'(sb));
            @(negedge clk);
        end
        req_valid = 2'b00;
        take_rsp("t3", 1);

        // Spurious eng_done in IDLE and in every ISSUE must be ignored
        set_labels(5'b11000);
        idle_req++;
        repeat (3) @(negedge clk);
        check_eq("t4.idle_busy", SW'(busy), SW'(0));
        spur = 1'b1;
        s0 = starts;
        request("t4", 2'b01, 2'b01, t);
        wait_rsp("t4", 0, t, 2 * NT + 2);
        check_eq("t4.rsp_label", SW'(rsp_label), SW'(2'b00));
        check_eq("t4.starts",    SW'(starts - s0), SW'(NT));
        take_rsp("t4", 0);
        spur = 1'b0;

`ifdef FOREST_TIMEOUT_EN
        // Engine silent on tree 2: 64 WAIT cycles then error response
        set_labels(5'b11111);
        silent_tree = 2;
        request("t5", 2'b10, 2'b10, t);
        wait_rsp("t5", 1, t, 6 + 64);
        check_eq("t5.rsp_valid", SW'(rsp_valid), SW'(2'b10));
        check_eq("t5.rsp_err",   SW'(rsp_err),   SW'(2'b10));
        check_eq("t5.rsp_label", SW'(rsp_label), SW'(2'b00));
        take_rsp("t5", 1);
        check_eq("t5.err_clr", SW'(rsp_err), SW'(0));
        silent_tree = -1;
`endif

        // Reset during WAIT of tree 3, then a fresh evaluation from tree 0
        set_labels(5'b01101);
        silent_tree = 3;
        request("t6", 2'b01, 2'b01, t);
        while (cyc < t + 8) @(negedge clk);
        check_eq("t6.tree_sel3", SW'(eng_tree_sel), SW'(3));
        check_eq("t6.busy_pre",  SW'(busy), SW'(1));
        reset = 1'b0;
        #1;
        check_reset_outputs("t6.async");
        @(negedge clk);
        check_reset_outputs("t6.edge");
        reset = 1'b1;
        silent_tree = -1;
        s0 = starts;
        request("t6b", 2'b11, 2'b01, t);
        check_eq("t6b.eng_start", SW'(eng_start), SW'(1));
        check_eq("t6b.tree_sel0", SW'(eng_tree_sel), SW'(0));
        wait_rsp("t6b", 0, t, 2 * NT + 2);
        check_eq("t6b.rsp_label", SW'(rsp_label), SW'(2'b01));
        check_eq("t6b.starts",    SW'(starts - s0), SW'(NT));
        take_rsp("t6b", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
